// File: rtl/fix_checksum_gen_if.sv
// Purpose : beat input, result and serial-digit signals of the FIX checksum generator.
// Latency : none, wiring only.
// Backpressure: ready_o gates input beats, ser_ready_i gates serial digits.
interface fix_checksum_gen_if #(
  parameter int LANES = 1
);
  logic                 valid_i;
  logic                 ready_o;
  logic                 start_i;
  logic                 end_i;
  logic [8*LANES-1:0]   data_i;
  logic [LANES-1:0]     keep_i;
  logic [7:0]           checksum_o;
  logic [23:0]          ascii_o;
  logic                 done_o;
  logic                 abort_o;
  logic                 ser_valid_o;
  logic                 ser_ready_i;
  logic [7:0]           ser_data_o;

  // Checksum block side.
  modport slave (
    input  valid_i, start_i, end_i, data_i, keep_i, ser_ready_i,
    output ready_o, checksum_o, ascii_o, done_o, abort_o, ser_valid_o, ser_data_o
  );

  // Upstream datapath / downstream trailer-inserter side.
  modport master (
    output valid_i, start_i, end_i, data_i, keep_i, ser_ready_i,
    input  ready_o, checksum_o, ascii_o, done_o, abort_o, ser_valid_o, ser_data_o
  );
endinterface

// File: rtl/fix_checksum_gen.sv
// Purpose : FIX tag-10 checksum, mod-256 byte sum of a framed message rendered as 3 ASCII digits.
// Latency : done_o/ascii_o/first serial digit two cycles after the end beat is accepted.
// Backpressure: ready_o low from the cycle after the end beat until the units digit is consumed.
module fix_checksum_gen #(
  parameter int         LANES    = 1,
  parameter logic [7:0] SEED     = 8'd0,
  parameter logic [7:0] TAIL_SUB = 8'd0
) (
  input  logic              clk,
  input  logic              rst,
  fix_checksum_gen_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_CONV  = 2'd2,
    S_SER   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  sum_q, sum_d;
  logic [7:0]  checksum_q, checksum_d;
  logic [23:0] ascii_q, ascii_d;
  logic        done_q, done_d;
  logic        ser_valid_q, ser_valid_d;
  logic [7:0]  ser_data_q, ser_data_d;
  logic [1:0]  dig_q, dig_d;

  logic        ready;
  logic        accept;
  logic        abort;
  logic [7:0]  beat_sum;
  logic [7:0]  add_sum;
  logic [7:0]  fin_sum;
  logic [23:0] ascii_conv;

  // Three ASCII decimal digits of an 8-bit value, hundreds in the top byte.
  function automatic logic [23:0] to_ascii(input logic [7:0] v);
    logic [7:0] h, t, u;
    h = v / 8'd100;
    t = (v / 8'd10) % 8'd10;
    u = v % 8'd10;
    return {h + 8'h30, t + 8'h30, u + 8'h30};
  endfunction

  // Input side is open only while framing a message; depends on state alone.
  assign ready  = (state_q == S_IDLE) || (state_q == S_ACCUM);
  assign accept = bus.valid_i & ready;

  // Sum of the enabled lanes of the current beat, mod 256.
  always_comb begin
    beat_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.keep_i[i]) begin
        beat_sum = beat_sum + bus.data_i[8*i +: 8];
      end
    end
  end

  // Candidate running sums: a start beat reseeds, the end beat also drops the tail bytes.
  always_comb begin
    add_sum    = (bus.start_i ? SEED : sum_q) + beat_sum;
    fin_sum    = add_sum - TAIL_SUB;
    ascii_conv = to_ascii(sum_q);
  end

  // Next-state logic for framing, conversion and serial digit sequencing.
  always_comb begin
    state_d     = state_q;
    sum_d       = sum_q;
    checksum_d  = checksum_q;
    ascii_d     = ascii_q;
    done_d      = 1'b0;
    ser_valid_d = ser_valid_q;
    ser_data_d  = ser_data_q;
    dig_d       = dig_q;
    abort       = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Beats without start_i are dropped silently while idle.
        if (accept && bus.start_i) begin
          sum_d   = bus.end_i ? fin_sum : add_sum;
          state_d = bus.end_i ? S_CONV : S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          abort   = bus.start_i;
          sum_d   = bus.end_i ? fin_sum : add_sum;
          state_d = bus.end_i ? S_CONV : S_ACCUM;
        end
      end
      S_CONV: begin
        checksum_d  = sum_q;
        ascii_d     = ascii_conv;
        done_d      = 1'b1;
        ser_valid_d = 1'b1;
        ser_data_d  = ascii_conv[23:16];
        dig_d       = 2'd0;
        state_d     = S_SER;
      end
      S_SER: begin
        if (ser_valid_q && bus.ser_ready_i) begin
          case (dig_q)
            2'd0: begin
              ser_data_d = ascii_q[15:8];
              dig_d      = 2'd1;
            end
            2'd1: begin
              ser_data_d = ascii_q[7:0];
              dig_d      = 2'd2;
            end
            default: begin
              ser_valid_d = 1'b0;
              ser_data_d  = 8'd0;
              dig_d       = 2'd0;
              state_d     = S_IDLE;
            end
          endcase
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any message or stream in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sum_q       <= 8'd0;
      checksum_q  <= 8'd0;
      ascii_q     <= 24'd0;
      done_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_data_q  <= 8'd0;
      dig_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      checksum_q  <= checksum_d;
      ascii_q     <= ascii_d;
      done_q      <= done_d;
      ser_valid_q <= ser_valid_d;
      ser_data_q  <= ser_data_d;
      dig_q       <= dig_d;
    end
  end

  assign bus.ready_o     = ready;
  assign bus.abort_o     = abort;
  assign bus.checksum_o  = checksum_q;
  assign bus.ascii_o     = ascii_q;
  assign bus.done_o      = done_q;
  assign bus.ser_valid_o = ser_valid_q;
  assign bus.ser_data_o  = ser_data_q;

endmodule

// File: tb/tb_fix_checksum_gen.sv
// Purpose : directed and randomized checks of two checksum generator configurations.
// Latency : expects results two cycles after the end beat, digits one per handshake.
// Backpressure: exercises serial stalls and verifies ready_o stays low while streaming.
module tb_fix_checksum_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fix_checksum_gen_if #(.LANES(1)) ifa ();
  fix_checksum_gen_if #(.LANES(4)) ifb ();

  // Instance 0: plain single-lane; instance 1: 4 lanes with header seed and tail exclusion.
  fix_checksum_gen #(.LANES(1), .SEED(8'd0), .TAIL_SUB(8'd0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );
  fix_checksum_gen #(.LANES(4), .SEED(8'd117), .TAIL_SUB(8'd97)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: unbounded integer sum of kept bytes per instance.
  int acc [2];
  bit act [2];
  int exp_sum [2];

  // Per-instance output views.
  logic        rdy [2];
  logic        dn  [2];
  logic        ab  [2];
  logic        sv  [2];
  logic [7:0]  sd  [2];
  logic [7:0]  cs  [2];
  logic [23:0] asc [2];

  assign rdy[0] = ifa.ready_o;     assign rdy[1] = ifb.ready_o;
  assign dn[0]  = ifa.done_o;      assign dn[1]  = ifb.done_o;
  assign ab[0]  = ifa.abort_o;     assign ab[1]  = ifb.abort_o;
  assign sv[0]  = ifa.ser_valid_o; assign sv[1]  = ifb.ser_valid_o;
  assign sd[0]  = ifa.ser_data_o;  assign sd[1]  = ifb.ser_data_o;
  assign cs[0]  = ifa.checksum_o;  assign cs[1]  = ifb.checksum_o;
  assign asc[0] = ifa.ascii_o;     assign asc[1] = ifb.ascii_o;

  function automatic int seed_of(input bit b);
    return b ? 117 : 0;
  endfunction

  function automatic int tail_of(input bit b);
    return b ? 97 : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_ser_ready(input bit b, input logic v);
    if (b) ifb.ser_ready_i = v;
    else   ifa.ser_ready_i = v;
  endtask

  // Present one beat, wait for acceptance, update the model. fin=1 if it closed a message.
  task automatic beat(input bit b, input bit s, input bit e, input logic [31:0] d,
                      input logic [3:0] k, output bit fin);
    int n = 0;
    int add = 0;
    if (b) begin
      ifb.valid_i = 1'b1; ifb.start_i = s; ifb.end_i = e; ifb.data_i = d; ifb.keep_i = k;
    end else begin
      ifa.valid_i = 1'b1; ifa.start_i = s; ifa.end_i = e; ifa.data_i = d[7:0]; ifa.keep_i = k[0];
    end
    #1;
    while (!rdy[b] && n < 20) begin
      @(posedge clk); #1; n++;
    end
    check("beat_ready", {31'd0, rdy[b]}, 32'd1);
    check("abort", {31'd0, ab[b]}, {31'd0, s && act[b]});
    for (int i = 0; i < (b ? 4 : 1); i++) begin
      if (k[i]) add += int'(d[8*i +: 8]);
    end
    fin = 1'b0;
    if (s) begin
      acc[b] = seed_of(b) + add;
      act[b] = 1'b1;
    end else if (act[b]) begin
      acc[b] += add;
    end
    if (e && act[b]) begin
      exp_sum[b] = (((acc[b] - tail_of(b)) % 256) + 256) % 256;
      act[b] = 1'b0;
      fin = 1'b1;
    end
    @(posedge clk); #1;
    if (b) begin
      ifb.valid_i = 1'b0; ifb.start_i = 1'b0; ifb.end_i = 1'b0;
    end else begin
      ifa.valid_i = 1'b0; ifa.start_i = 1'b0; ifa.end_i = 1'b0;
    end
  endtask

  // Called #1 after the end-beat edge: checks CONV gap, done pulse, outputs and serial digits.
  task automatic result(input bit b, input int stall, input bit rnd, input int lit);
    string       s;
    int          exp;
    logic [23:0] ea;
    logic [7:0]  dig;
    int          st;
    exp = (lit >= 0) ? lit : exp_sum[b];
    s   = $sformatf("%03d", exp);
    ea  = {s[0], s[1], s[2]};
    check("conv_ready", {31'd0, rdy[b]}, 32'd0);
    check("conv_done", {31'd0, dn[b]}, 32'd0);
    check("conv_ser_valid", {31'd0, sv[b]}, 32'd0);
    @(posedge clk); #1;
    check("done_pulse", {31'd0, dn[b]}, 32'd1);
    check("checksum", {24'd0, cs[b]}, exp);
    check("ascii", {8'd0, asc[b]}, {8'd0, ea});
    check("ser_valid_first", {31'd0, sv[b]}, 32'd1);
    for (int i = 0; i < 3; i++) begin
      dig = ea[23 - 8*i -: 8];
      check("ser_digit", {24'd0, sd[b]}, {24'd0, dig});
      st = (i == 0) ? stall : (rnd ? int'($urandom_range(0, 2)) : 0);
      for (int j = 0; j < st; j++) begin
        set_ser_ready(b, 1'b0);
        @(posedge clk); #1;
        check("stall_hold", {24'd0, sd[b]}, {24'd0, dig});
        check("stall_valid", {31'd0, sv[b]}, 32'd1);
        check("stall_ready", {31'd0, rdy[b]}, 32'd0);
        check("stall_done", {31'd0, dn[b]}, 32'd0);
      end
      set_ser_ready(b, 1'b1);
      @(posedge clk); #1;
      set_ser_ready(b, 1'b0);
      check("post_hs_done", {31'd0, dn[b]}, 32'd0);
      if (i < 2) begin
        check("ser_valid_mid", {31'd0, sv[b]}, 32'd1);
        check("ready_mid", {31'd0, rdy[b]}, 32'd0);
      end
    end
    check("ser_valid_drop", {31'd0, sv[b]}, 32'd0);
    check("ready_back", {31'd0, rdy[b]}, 32'd1);
    check("checksum_held", {24'd0, cs[b]}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, observed=hang expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit fin;
    int len, rj;
    bit b, rs;
    ifa.valid_i = 0; ifa.start_i = 0; ifa.end_i = 0; ifa.data_i = '0; ifa.keep_i = '0; ifa.ser_ready_i = 0;
    ifb.valid_i = 0; ifb.start_i = 0; ifb.end_i = 0; ifb.data_i = '0; ifb.keep_i = '0; ifb.ser_ready_i = 0;
    act[0] = 0; act[1] = 0; acc[0] = 0; acc[1] = 0; exp_sum[0] = 0; exp_sum[1] = 0;

    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", {31'd0, ifa.ready_o}, 32'd1);
    check("rst_ser_valid", {31'd0, ifa.ser_valid_o}, 32'd0);
    check("rst_done", {31'd0, ifa.done_o}, 32'd0);
    check("rst_checksum", {24'd0, ifa.checksum_o}, 32'd0);
    check("rst_ascii", {8'd0, ifa.ascii_o}, 32'd0);
    check("rst_ser_data", {24'd0, ifb.ser_data_o}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // "ABC" -> 198, first digit held through 5 stall cycles.
    beat(0, 1, 0, 32'h41, 4'h1, fin);
    beat(0, 0, 0, 32'h42, 4'h1, fin);
    beat(0, 0, 1, 32'h43, 4'h1, fin);
    result(0, 5, 0, 198);

    // Wrap past 255.
    beat(0, 1, 0, 32'hFF, 4'h1, fin);
    beat(0, 0, 1, 32'h02, 4'h1, fin);
    result(0, 0, 0, 1);

    // Restart mid-message pulses abort and reseeds.
    beat(0, 1, 0, 32'h50, 4'h1, fin);
    beat(0, 0, 0, 32'h60, 4'h1, fin);
    beat(0, 1, 0, 32'h01, 4'h1, fin);
    beat(0, 0, 1, 32'h02, 4'h1, fin);
    result(0, 1, 0, 3);

    // Beats without start while idle are ignored, including a stray end.
    beat(0, 0, 0, 32'h77, 4'h1, fin);
    beat(0, 0, 1, 32'h11, 4'h1, fin);
    check("idle_ignore_done", {31'd0, ifa.done_o}, 32'd0);
    @(posedge clk); #1;
    check("idle_ignore_done2", {31'd0, ifa.done_o}, 32'd0);
    check("idle_ignore_ready", {31'd0, ifa.ready_o}, 32'd1);

    // Disabled lanes on start and end beats still frame the message.
    beat(0, 1, 0, 32'h99, 4'h0, fin);
    beat(0, 0, 1, 32'h05, 4'h0, fin);
    result(0, 0, 0, 0);

    // 4 lanes, single beat, lane 3 disabled: 117 + 6 - 97 = 26.
    beat(1, 1, 1, 32'h04030201, 4'b0111, fin);
    result(1, 2, 0, 26);

    // Seed/tail: 117 + 0x10 + 0x20 - 97 = 68.
    beat(1, 1, 0, 32'h00000010, 4'b0001, fin);
    beat(1, 0, 1, 32'h00000020, 4'b0001, fin);
    result(1, 0, 0, 68);

    // Reset during the serial stream abandons it.
    beat(0, 1, 1, 32'h05, 4'h1, fin);
    @(posedge clk); #1;
    check("pre_rst_ser_valid", {31'd0, ifa.ser_valid_o}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_ser_drop", {31'd0, ifa.ser_valid_o}, 32'd0);
    check("rst_ser_ready", {31'd0, ifa.ready_o}, 32'd1);
    ifa.ser_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("rst_no_digits", {31'd0, ifa.ser_valid_o}, 32'd0);
      check("rst_no_done", {31'd0, ifa.done_o}, 32'd0);
    end
    ifa.ser_ready_i = 1'b0;

    // Randomized messages on both instances against the model.
    for (int t = 0; t < 30; t++) begin
      b   = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 5);
      rs  = ($urandom_range(0, 3) == 0);
      rj  = $urandom_range(0, len - 1);
      if ($urandom_range(0, 3) == 0) begin
        beat(b, 0, 1'($urandom_range(0, 1)), $urandom, 4'($urandom), fin);
      end
      for (int j = 0; j < len; j++) begin
        beat(b, (j == 0) || (rs && j == rj), (j == len - 1), $urandom, 4'($urandom), fin);
      end
      check("rand_fin", {31'd0, fin}, 32'd1);
      result(b, $urandom_range(0, 3), 1, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
